tail_light_input_cond: RTL and testbench

TAIL_LIGHT_INPUT_COND -- requirements
Module: tail_light_input_cond

---
 rtl/tail_light_input_cond.sv | 85 ++++++++
 tb/tb_tail_light_input_cond.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tail_light_input_cond.sv
// Input conditioning for the tail-light sequencer: synchronizes and debounces the raw
// stalk and hazard contacts, resolves stalk conflicts and latches the hazard toggle.
module tail_light_input_cond #(
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic haz_btn,
    output logic LEFT,
    output logic RIGHT,
    output logic HAZ
);

    localparam int unsigned NumIn = 3;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    // Bit order for all per-input vectors: 0 = left, 1 = right, 2 = hazard.
    logic [NumIn-1:0] raw;
    logic [NumIn-1:0] s1_q, s1_d;
    logic [NumIn-1:0] s2_q, s2_d;
    logic [NumIn-1:0] db_q, db_d;
    logic [CNT_W-1:0] cnt_q [NumIn];
    logic [CNT_W-1:0] cnt_d [NumIn];
    logic             haz_dly_q, haz_dly_d;
    logic             haz_latch_q, haz_latch_d;
    logic             left_q, left_d;
    logic             right_q, right_d;

    assign raw = {haz_btn, right_sw, left_sw};

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        db_d = db_q;
        for (int i = 0; i < NumIn; i++) begin
            cnt_d[i] = '0;
            // A new level is accepted only after DB_CYCLES consecutive mismatching samples.
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        left_d      = db_q[0] & ~db_q[1];
        right_d     = db_q[1] & ~db_q[0];
        haz_dly_d   = db_q[2];
        haz_latch_d = haz_latch_q ^ (db_q[2] & ~haz_dly_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            db_q        <= '0;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= '0;
            end
            haz_dly_q   <= 1'b0;
            haz_latch_q <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            db_q        <= db_d;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            haz_dly_q   <= haz_dly_d;
            haz_latch_q <= haz_latch_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    assign LEFT  = left_q;
    assign RIGHT = right_q;
    assign HAZ   = haz_latch_q;

endmodule

// File: tb/tb_tail_light_input_cond.sv
// Bench for tail_light_input_cond with DB_CYCLES = 4: per-edge expected {LEFT,RIGHT,HAZ}
// values are queued as stimulus is driven and checked after each rising edge.
module tb_tail_light_input_cond;

    logic clk = 1'b0;
    logic reset;
    logic left_sw;
    logic right_sw;
    logic haz_btn;
    logic LEFT;
    logic RIGHT;
    logic HAZ;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  obs;
    logic [2:0]  exp_v;

    always #5 clk = ~clk;

    tail_light_input_cond #(
        .DB_CYCLES(4),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .left_sw (left_sw),
        .right_sw(right_sw),
        .haz_btn (haz_btn),
        .LEFT    (LEFT),
        .RIGHT   (RIGHT),
        .HAZ     (HAZ)
    );

    // Drive inputs, then advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick(input logic rst, input logic l, input logic r, input logic h);
        reset    = rst;
        left_sw  = l;
        right_sw = r;
        haz_btn  = h;
        @(posedge clk);
        #1;
        obs = {LEFT, RIGHT, HAZ};
    endtask

    task automatic apply_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(3'b000);
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back((k >= 7) ? 3'b100 : 3'b000);
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back(3'b000);
            tick(1'b1, (k <= 3), 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(3'b000);
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL conflict_both edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back((k >= 7) ? 3'b100 : 3'b000);
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL conflict_drop edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_hazard_toggle();
        apply_reset();
        // Phases: press, release, press, release; HAZ flips 7 edges into each press.
        for (int p = 0; p < 4; p++) begin
            for (int k = 1; k <= 20; k++) begin
                case (p)
                    0:       exp_q.push_back((k >= 7) ? 3'b001 : 3'b000);
                    1:       exp_q.push_back(3'b001);
                    2:       exp_q.push_back((k >= 7) ? 3'b000 : 3'b001);
                    default: exp_q.push_back(3'b000);
                endcase
                tick(1'b1, 1'b0, 1'b0, (p % 2 == 0));
                exp_v = exp_q.pop_front();
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL hazard phase %0d edge %0d: got %b want %b", p, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        logic       h;
        pat = 7'b0110101;  // bit i is the sample for cycle i: 1,0,1,0,1,1,0
        apply_reset();
        for (int i = 0; i < 42; i++) begin
            if (i < 7) h = pat[i];
            else if (i < 27) h = 1'b1;
            else h = (i < 33) ? i[0] : 1'b0;  // bouncy release, then stable low
            exp_q.push_back((i >= 13) ? 3'b001 : 3'b000);
            tick(1'b1, 1'b0, 1'b0, h);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_independent();
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back((k >= 7) ? 3'b101 : 3'b000);
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL left_haz edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back((k >= 7) ? 3'b010 : 3'b000);
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL right_only edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back((k >= 7) ? 3'b001 : 3'b000);
            tick(1'b1, 1'b0, 1'b0, (k <= 12));
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset_setup edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
        for (int k = 0; k <= 10; k++) begin
            exp_q.push_back(3'b000);
            tick((k != 0), 1'b0, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset edge %0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        left_sw  = 1'b0;
        right_sw = 1'b0;
        haz_btn  = 1'b0;
        test_reset();
        test_glitch();
        test_conflict();
        test_hazard_toggle();
        test_bounce();
        test_independent();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
